axi_mem_responder: RTL and testbench

AXI slave/responder that terminates the master-side AXI bundle (aw/w/b/ar/r channels) with an on-chip dual-port word memory and independent read and write engines. It is the far end of the DDR4 perf traffic generators, for simulation and FPGA loopback without the memory controller, with a programmable read latency that emulates DRAM turnaround. Bursts are INCR, one full DATA_WTH word per beat; there is no size, burst-type or strobe support.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_defs.svh | 10 +
 rtl/axi_dp_ram.sv | 28 ++
 rtl/axi_mem_responder.sv | 217 +++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI widths, response codes and engine state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "axi_defs.svh"

package axi_pkg;
    localparam int ID_W    = `AXI_ID_WTH;
    localparam int ADDR_W  = `AXI_ADDR_WTH;
    localparam int LEN_W   = `AXI_LEN_WTH;
    localparam int DATA_W  = `AXI_DATA_WTH;
    localparam int RESP_W  = `AXI_RESP_WTH;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int IDX_W   = ADDR_W - BYTE_SH;

    localparam logic [RESP_W-1:0] RESP_OKAY   = RESP_W'(0);
    localparam logic [RESP_W-1:0] RESP_SLVERR = RESP_W'(2);

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx, input int depth);
        return idx < IDX_W'(depth);
    endfunction
endpackage

// File: rtl/axi_defs.svh
`ifndef AXI_DEFS_SVH
`define AXI_DEFS_SVH

`define AXI_ID_WTH   4
`define AXI_ADDR_WTH 32
`define AXI_LEN_WTH  8
`define AXI_DATA_WTH 64
`define AXI_RESP_WTH 2

`endif

// File: rtl/axi_dp_ram.sv
// Simple dual-port word memory: one write port, one registered read port.
// Latency: read data valid one cycle after re; read-during-write returns old data.
// Backpressure: none; dout holds its value while re is low.
module axi_dp_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Array is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    dout <= '0;
        else if (re) dout <= mem[raddr];
    end
endmodule

// File: rtl/axi_mem_responder.sv
// AXI slave terminating aw/w/b/ar/r onto an on-chip word memory, INCR full-width beats.
// Latency: first rvalid RD_LAT cycles after ar handshake, then one beat per cycle.
// Backpressure: r outputs held while rready=0; ce=0 freezes everything and drops the readies.
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [RESP_W-1:0] bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [RESP_W-1:0] rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RD_LAT + 1);

    wr_state_t        wr_state;
    logic             awready_q, wready_q;
    logic [ID_W-1:0]  wr_id;
    logic [IDX_W-1:0] wr_idx;
    logic [LEN_W-1:0] wr_len, wr_cnt;
    logic             wr_err, wr_over;
    logic             aw_hs, w_hs, wr_ok, ram_we;

    assign awready = awready_q & ce;
    assign wready  = wready_q & ce;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign wr_ok   = idx_in_range(wr_idx, DEPTH);
    // Beats past awlen+1 are accepted on the bus but never reach memory.
    assign ram_we  = w_hs & wr_ok & ~wr_over;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state  <= WR_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= RESP_OKAY;
            wr_id     <= '0;
            wr_idx    <= '0;
            wr_len    <= '0;
            wr_cnt    <= '0;
            wr_err    <= 1'b0;
            wr_over   <= 1'b0;
        end else if (ce) begin
            case (wr_state)
                WR_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wr_id     <= awid;
                        wr_idx    <= awaddr[ADDR_W-1:BYTE_SH];
                        wr_len    <= awlen;
                        wr_cnt    <= '0;
                        wr_err    <= 1'b0;
                        wr_over   <= 1'b0;
                        wr_state  <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        wr_idx  <= wr_idx + IDX_W'(1);
                        wr_err  <= wr_err | ~wr_ok;
                        wr_over <= wr_over | (wr_cnt == wr_len);
                        if (!wr_over) wr_cnt <= wr_cnt + LEN_W'(1);
                        if (wlast) begin
                            wready_q <= 1'b0;
                            bvalid   <= 1'b1;
                            bid      <= wr_id;
                            bresp    <= (wr_err | ~wr_ok | wr_over | (wr_cnt != wr_len))
                                        ? RESP_SLVERR : RESP_OKAY;
                            wr_state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready_q <= 1'b1;
                        wr_state  <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    rd_state_t        rd_state;
    logic             arready_q;
    logic [ID_W-1:0]  rd_id;
    logic [IDX_W-1:0] rd_idx, rd_nxt;
    logic [LEN_W-1:0] rd_len, rd_cnt, rd_cnt_nxt;
    logic [CW-1:0]    lat_cnt;
    logic             ar_hs, ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [DATA_W-1:0] ram_dout;

    assign arready    = arready_q & ce;
    assign ar_hs      = arvalid & arready;
    assign rd_nxt     = rd_idx + IDX_W'(1);
    assign rd_cnt_nxt = rd_cnt + LEN_W'(1);
    assign rdata      = (rresp == RESP_SLVERR) ? '0 : ram_dout;

    // The RAM output register is the prefetch stage: it only advances when the
    // current beat is consumed, so stalls hold rdata and streaming has no bubbles.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = rd_idx[AW-1:0];
        if (ce) begin
            if (rd_state == RD_WAIT && lat_cnt == '0) begin
                ram_re = 1'b1;
            end else if (rd_state == RD_DATA && rready && !rlast) begin
                ram_re    = 1'b1;
                ram_raddr = rd_nxt[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid    <= 1'b0;
            rid       <= '0;
            rresp     <= RESP_OKAY;
            rlast     <= 1'b0;
            rd_id     <= '0;
            rd_idx    <= '0;
            rd_len    <= '0;
            rd_cnt    <= '0;
            lat_cnt   <= '0;
        end else if (ce) begin
            case (rd_state)
                RD_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rd_id     <= arid;
                        rd_idx    <= araddr[ADDR_W-1:BYTE_SH];
                        rd_len    <= arlen;
                        rd_cnt    <= '0;
                        lat_cnt   <= CW'(RD_LAT - 1);
                        rd_state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end else begin
                        rvalid   <= 1'b1;
                        rid      <= rd_id;
                        rresp    <= idx_in_range(rd_idx, DEPTH) ? RESP_OKAY : RESP_SLVERR;
                        rlast    <= (rd_len == '0);
                        rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            arready_q <= 1'b1;
                            rd_state  <= RD_IDLE;
                        end else begin
                            rd_idx <= rd_nxt;
                            rd_cnt <= rd_cnt_nxt;
                            rresp  <= idx_in_range(rd_nxt, DEPTH) ? RESP_OKAY : RESP_SLVERR;
                            rlast  <= (rd_cnt_nxt == rd_len);
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    axi_dp_ram #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_idx[AW-1:0]),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .dout  (ram_dout)
    );

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{awaddr[BYTE_SH-1:0], araddr[BYTE_SH-1:0]};
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, error responses, stalls, reset and ce freeze.
`timescale 1ns/1ps
module tb_axi_mem_responder;
    import axi_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 4;

    logic clk = 1'b0;
    logic rst, ce;
    logic [ID_W-1:0]   awid, bid, arid, rid;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [LEN_W-1:0]  awlen, arlen;
    logic [DATA_W-1:0] wdata, rdata;
    logic [RESP_W-1:0] bresp, rresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] model [DEPTH];

    always #5 clk = ~clk;

    axi_mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int idx, input int salt);
        return {32'(salt), 32'(idx)};
    endfunction

    function automatic logic [63:0] exp_data(input int idx);
        if (idx < DEPTH) return model[idx];
        return 64'd0;
    endfunction

    task automatic aw_send(input int id, input int idx, input int len);
        int n = 0;
        awid = ID_W'(id); awaddr = ADDR_W'(idx << BYTE_SH); awlen = LEN_W'(len); awvalid = 1'b1;
        while (!awready && n < 200) begin tick(); n++; end
        check("aw_ready", awready, 1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic last);
        int n = 0;
        wdata = d; wlast = last; wvalid = 1'b1;
        while (!wready && n < 200) begin tick(); n++; end
        check("w_ready", wready, 1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input int id, input int resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < 200) begin tick(); n++; end
        check("b_valid", bvalid, 1);
        check("bid", bid, 64'(id));
        check("bresp", bresp, 64'(resp));
        check("aw_rdy_in_resp", awready, 0);
        tick();
        bready = 1'b0;
        check("aw_rdy_after_b", awready, 1);
    endtask

    task automatic w_burst(input int id, input int idx0, input int len, input int nbeats,
                           input int salt, input int resp);
        aw_send(id, idx0, len);
        for (int i = 0; i < nbeats; i++) begin
            w_send(pat(idx0 + i, salt), i == nbeats - 1);
            if (i <= len && idx0 + i < DEPTH) model[idx0 + i] = pat(idx0 + i, salt);
        end
        b_recv(id, resp);
    endtask

    task automatic ar_send(input int id, input int idx, input int len, output int lat);
        int n = 0;
        arid = ID_W'(id); araddr = ADDR_W'(idx << BYTE_SH); arlen = LEN_W'(len); arvalid = 1'b1;
        while (!arready && n < 200) begin tick(); n++; end
        check("ar_ready", arready, 1);
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 200) begin tick(); lat++; end
    endtask

    // mode 0: rready always 1; mode 1: rready pattern 1,0,0 repeating
    task automatic r_burst(input int id, input int idx0, input int len, input int mode);
        int b = 0;
        int cyc = 0;
        while (b <= len && cyc < 1000) begin
            rready = (mode == 0) || (cyc % 3 == 0);
            if (rvalid) begin
                check("rid", rid, 64'(id));
                check("rdata", rdata, exp_data(idx0 + b));
                check("rresp", rresp, (idx0 + b < DEPTH) ? 64'(RESP_OKAY) : 64'(RESP_SLVERR));
                check("rlast", rlast, 64'(b == len));
                if (rready) b++;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", 64'(b), 64'(len + 1));
        check("r_cycles", 64'(cyc), (mode == 0) ? 64'(len + 1) : 64'(3 * len + 1));
        check("r_idle_valid", rvalid, 0);
        check("ar_rdy_after_rlast", arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b0; ce = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) tick();

        check("rst_readies", {awready, wready, arready}, 0);
        check("rst_valids", {bvalid, rvalid, rlast}, 0);
        check("rst_ids_resps", {bid, rid, bresp, rresp}, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b1;
        #1;
        check("rdy_before_edge", {awready, arready}, 0);
        tick();
        check("rdy_after_edge", {awready, arready}, 2'b11);

        // Basic 4-beat write then read-back with latency measurement
        w_burst(3, 8, 3, 4, 1, 0);
        ar_send(5, 8, 3, lat);
        check("rd_latency", 64'(lat), 64'(RD_LAT));
        r_burst(5, 8, 3, 0);

        // len=7 read under rready 1,0,0 back-pressure
        w_burst(1, 16, 7, 8, 2, 0);
        ar_send(2, 16, 7, lat);
        check("rd_latency_2", 64'(lat), 64'(RD_LAT));
        r_burst(2, 16, 7, 1);

        // Early wlast, out-of-range write beat, out-of-range read beat
        w_burst(1, 64, 3, 2, 3, 2);
        w_burst(2, DEPTH - 1, 1, 2, 4, 2);
        ar_send(3, DEPTH - 1, 1, lat);
        r_burst(3, DEPTH - 1, 1, 0);

        // Overrun: extra beat past awlen+1 is discarded
        w_burst(4, 100, 1, 2, 5, 0);
        w_burst(4, 100, 0, 2, 6, 2);
        ar_send(4, 100, 1, lat);
        r_burst(4, 100, 1, 0);

        // Concurrent 16-beat read and write on disjoint ranges
        w_burst(8, 200, 15, 16, 7, 0);
        fork
            begin
                int clat;
                ar_send(7, 200, 15, clat);
                check("rd_latency_conc", 64'(clat), 64'(RD_LAT));
                r_burst(7, 200, 15, 0);
            end
            begin
                w_burst(9, 300, 15, 16, 8, 0);
            end
        join
        ar_send(9, 300, 15, lat);
        r_burst(9, 300, 15, 0);

        // Reset in the middle of both bursts
        aw_send(2, 400, 3);
        w_send(pat(400, 9), 1'b0); model[400] = pat(400, 9);
        w_send(pat(401, 9), 1'b0); model[401] = pat(401, 9);
        ar_send(4, 16, 3, lat);
        check("pre_rst_rvalid", rvalid, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valids", {bvalid, rvalid, rlast, wready}, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_ids", {rid, rresp}, 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_rdy", {awready, arready}, 2'b11);
        w_burst(6, 500, 1, 2, 10, 0);
        ar_send(6, 500, 1, lat);
        r_burst(6, 500, 1, 0);
        ar_send(6, 8, 3, lat);
        r_burst(6, 8, 3, 0);
        ar_send(6, 400, 1, lat);
        r_burst(6, 400, 1, 0);

        // ce=0 for 5 cycles during the latency count, then during a presented beat
        arid = ID_W'(5); araddr = ADDR_W'(16 << BYTE_SH); arlen = LEN_W'(3); arvalid = 1'b1;
        check("ce_ar_ready", arready, 1);
        tick();
        arvalid = 1'b0;
        lat = 0;
        repeat (2) begin tick(); lat++; end
        ce = 1'b0;
        #1;
        check("ce_forces_awready", awready, 0);
        repeat (5) begin
            tick(); lat++;
            check("ce_wait_rvalid", rvalid, 0);
        end
        ce = 1'b1;
        while (!rvalid && lat < 200) begin tick(); lat++; end
        check("ce_latency", 64'(lat), 64'(RD_LAT + 5));
        ce = 1'b0; rready = 1'b1;
        repeat (5) begin
            tick();
            check("ce_hold_rvalid", rvalid, 1);
            check("ce_hold_rdata", rdata, model[16]);
        end
        ce = 1'b1;
        r_burst(5, 16, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
